// File: rtl/dcache_port_sched_pkg.sv
// Shared types for the data-cache port scheduler: FSM state encoding and
// the payload values driven when a port carries no store data.
package dcache_port_sched_pkg;

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_LD_REQ,
        SCHED_LD_WAIT,
        SCHED_ST_REQ,
        SCHED_ST_WAIT,
        SCHED_UC_REQ,
        SCHED_UC_WAIT
    } sched_state_t;

    localparam logic [3:0]  SB_RWEN_NOP = 4'b0000;
    localparam logic [31:0] SB_DATA_NOP = 32'h0000_0000;

endpackage

// File: rtl/dcache_port_sched_starve_cnt.sv
// Saturating count of load grants issued while a store_buffer head waits.
// sat tells the arbiter the store must win the next decision.
module dcache_port_sched_starve_cnt
    import dcache_port_sched_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    assign sat = (cnt == LIMIT_V);

    always_ff @(posedge clk) begin
        if (rst_)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/dcache_port_sched.sv
// Arbitrates the single dcache request port between MEM-stage loads and
// store_buffer drain; uncached head entries go to the uncached bus port.
module dcache_port_sched
    import dcache_port_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        flush,
    input  logic        ld_req_valid,
    input  logic [31:0] ld_req_addr,
    output logic        ld_req_ready,
    output logic        ld_resp_valid,
    output logic [31:0] ld_resp_data,
    input  logic        sb_head_en,
    input  logic        sb_head_unc,
    input  logic [31:0] sb_head_addr,
    input  logic [31:0] sb_head_data,
    input  logic [3:0]  sb_head_wen,
    input  logic        sb_allow_in,
    output logic        sb_cache_busy,
    output logic        c_req_valid,
    output logic        c_req_wr,
    output logic [31:0] c_req_addr,
    output logic [31:0] c_req_wdata,
    output logic [3:0]  c_req_wen,
    input  logic        c_req_ready,
    input  logic        c_resp_valid,
    input  logic [31:0] c_resp_rdata,
    output logic        u_req_valid,
    output logic [31:0] u_req_addr,
    output logic [31:0] u_req_wdata,
    output logic [3:0]  u_req_wen,
    input  logic        u_req_ready,
    input  logic        u_resp_valid
);

    sched_state_t state, state_nxt;
    logic         kill;
    logic         head_any, store_win, starve_sat;
    logic         ld_grant, st_grant;

    assign head_any  = sb_head_en | sb_head_unc;
    assign store_win = head_any && (!sb_allow_in || starve_sat || !ld_req_valid);

    dcache_port_sched_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_cnt (
        .clk  (clk),
        .rst_ (rst_),
        .inc  (ld_grant && head_any),
        .clr  (st_grant || !head_any),
        .sat  (starve_sat)
    );

    always_comb begin
        // NOTE: every output of this block is given a default before the case so no latch is inferred.
        state_nxt     = state;
        ld_req_ready  = 1'b0;
        c_req_valid   = 1'b0;
        u_req_valid   = 1'b0;
        sb_cache_busy = 1'b1;
        ld_grant      = 1'b0;
        st_grant      = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (store_win) begin
                    st_grant  = 1'b1;
                    state_nxt = sb_head_en ? SCHED_ST_REQ : SCHED_UC_REQ;
                end else if (ld_req_valid && !flush) begin
                    ld_grant     = 1'b1;
                    ld_req_ready = 1'b1;
                    state_nxt    = SCHED_LD_REQ;
                end
            end
            SCHED_LD_REQ: begin
                c_req_valid = 1'b1;
                if (c_req_ready) state_nxt = SCHED_LD_WAIT;
            end
            SCHED_LD_WAIT: if (c_resp_valid) state_nxt = SCHED_IDLE;
            SCHED_ST_REQ: begin
                c_req_valid = 1'b1;
                if (c_req_ready) begin
                    sb_cache_busy = 1'b0;
                    state_nxt     = SCHED_ST_WAIT;
                end
            end
            SCHED_ST_WAIT: if (c_resp_valid) state_nxt = SCHED_IDLE;
            SCHED_UC_REQ: begin
                u_req_valid = 1'b1;
                if (u_req_ready) begin
                    sb_cache_busy = 1'b0;
                    state_nxt     = SCHED_UC_WAIT;
                end
            end
            SCHED_UC_WAIT: if (u_resp_valid) state_nxt = SCHED_IDLE;
            default: state_nxt = SCHED_IDLE;
        endcase
        // Reset cycle: no grant, no handshake, no pop may escape.
        if (rst_) begin
            ld_req_ready  = 1'b0;
            c_req_valid   = 1'b0;
            u_req_valid   = 1'b0;
            sb_cache_busy = 1'b1;
            ld_grant      = 1'b0;
            st_grant      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every update sees pre-edge values.
        if (rst_) state <= SCHED_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            kill          <= 1'b0;
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= '0;
            c_req_wr      <= 1'b0;
            c_req_addr    <= '0;
            c_req_wdata   <= SB_DATA_NOP;
            c_req_wen     <= SB_RWEN_NOP;
            u_req_addr    <= '0;
            u_req_wdata   <= SB_DATA_NOP;
            u_req_wen     <= SB_RWEN_NOP;
        end else begin
            ld_resp_valid <= 1'b0;
            if (ld_grant) begin
                c_req_wr    <= 1'b0;
                c_req_addr  <= ld_req_addr;
                c_req_wdata <= SB_DATA_NOP;
                c_req_wen   <= SB_RWEN_NOP;
            end
            // Head payload is captured here, before the pop lets store_buffer advance.
            if (st_grant && sb_head_en) begin
                c_req_wr    <= 1'b1;
                c_req_addr  <= sb_head_addr;
                c_req_wdata <= sb_head_data;
                c_req_wen   <= sb_head_wen;
            end
            if (st_grant && !sb_head_en) begin
                u_req_addr  <= sb_head_addr;
                u_req_wdata <= sb_head_data;
                u_req_wen   <= sb_head_wen;
            end
            if (state == SCHED_LD_WAIT && c_resp_valid) begin
                ld_resp_valid <= !kill && !flush;
                if (!kill && !flush) ld_resp_data <= c_resp_rdata;
            end
            // A flushed load still finishes on the bus; only its delivery is dropped.
            if (state_nxt == SCHED_IDLE) kill <= 1'b0;
            else if (flush)              kill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_port_sched.sv
// Directed bench with request/response scoreboards for dcache_port_sched,
// including simple dcache, uncached bus and store_buffer head models.
module tb_dcache_port_sched;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
    } req_t;

    logic        clk, rst_, flush;
    logic        ld_req_valid, ld_req_ready, ld_resp_valid;
    logic [31:0] ld_req_addr, ld_resp_data;
    logic        sb_head_en, sb_head_unc, sb_allow_in, sb_cache_busy;
    logic [31:0] sb_head_addr, sb_head_data;
    logic [3:0]  sb_head_wen;
    logic        c_req_valid, c_req_wr, c_req_ready, c_resp_valid;
    logic [31:0] c_req_addr, c_req_wdata, c_resp_rdata;
    logic [3:0]  c_req_wen;
    logic        u_req_valid, u_req_ready, u_resp_valid;
    logic [31:0] u_req_addr, u_req_wdata;
    logic [3:0]  u_req_wen;

    req_t        exp_c[$];
    req_t        exp_u[$];
    logic [31:0] exp_ld[$];
    logic [31:0] ld_pending[$];

    int          checks, passed;
    int          cyc, c_hs_cnt, u_hs_cnt, pops, grants, resps;
    int          c_cnt, u_cnt, c_lat, u_lat;
    int          last_grant_cyc, last_resp_cyc;
    logic        last_ready;
    logic [31:0] c_rd_addr;

    dcache_port_sched #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_(rst_), .flush(flush),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .sb_head_en(sb_head_en), .sb_head_unc(sb_head_unc), .sb_head_addr(sb_head_addr),
        .sb_head_data(sb_head_data), .sb_head_wen(sb_head_wen), .sb_allow_in(sb_allow_in),
        .sb_cache_busy(sb_cache_busy),
        .c_req_valid(c_req_valid), .c_req_wr(c_req_wr), .c_req_addr(c_req_addr),
        .c_req_wdata(c_req_wdata), .c_req_wen(c_req_wen), .c_req_ready(c_req_ready),
        .c_resp_valid(c_resp_valid), .c_resp_rdata(c_resp_rdata),
        .u_req_valid(u_req_valid), .u_req_addr(u_req_addr), .u_req_wdata(u_req_wdata),
        .u_req_wen(u_req_wen), .u_req_ready(u_req_ready), .u_resp_valid(u_resp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        return (addr == 32'h0000_1000) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_A5A5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic void drive_ld();
        if (ld_pending.size() != 0) begin
            ld_req_valid = 1'b1;
            ld_req_addr  = ld_pending[0];
        end else begin
            ld_req_valid = 1'b0;
            ld_req_addr  = 32'h0;
        end
    endfunction

    function automatic void exp_load(input logic [31:0] addr, input logic deliver);
        exp_c.push_back('{1'b0, addr, 32'h0, 4'h0});
        if (deliver) exp_ld.push_back(model_rdata(addr));
    endfunction

    function automatic void exp_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] wen);
        exp_c.push_back('{1'b1, addr, data, wen});
    endfunction

    // One clock: observe at negedge, then drive models and stimulus just after posedge.
    task automatic tick();
        req_t e;
        logic c_hs_wr, u_hs_now;
        @(negedge clk);
        cyc++;
        c_hs_wr    = 1'b0;
        u_hs_now   = 1'b0;
        last_ready = 1'b0;
        if (!rst_) begin
            last_ready = ld_req_ready;
            if (c_req_valid && c_req_ready) begin
                c_hs_cnt++;
                c_hs_wr = c_req_wr;
                check("c_req expected", 32'(exp_c.size() != 0), 32'd1);
                if (exp_c.size() != 0) begin
                    e = exp_c.pop_front();
                    check("c_req_wr", 32'(c_req_wr), 32'(e.wr));
                    check("c_req_addr", c_req_addr, e.addr);
                    check("c_req_wdata", c_req_wdata, e.wdata);
                    check("c_req_wen", 32'(c_req_wen), 32'(e.wen));
                end
                c_cnt     = c_lat;
                c_rd_addr = c_req_addr;
            end
            if (u_req_valid && u_req_ready) begin
                u_hs_cnt++;
                u_hs_now = 1'b1;
                check("u_req expected", 32'(exp_u.size() != 0), 32'd1);
                if (exp_u.size() != 0) begin
                    e = exp_u.pop_front();
                    check("u_req_addr", u_req_addr, e.addr);
                    check("u_req_wdata", u_req_wdata, e.wdata);
                    check("u_req_wen", 32'(u_req_wen), 32'(e.wen));
                end
                u_cnt = u_lat;
            end
            if (!sb_cache_busy) begin
                pops++;
                check("pop at store accept", 32'(c_hs_wr || u_hs_now), 32'd1);
            end
            if (ld_resp_valid) begin
                resps++;
                last_resp_cyc = cyc;
                check("ld_resp expected", 32'(exp_ld.size() != 0), 32'd1);
                if (exp_ld.size() != 0) check("ld_resp_data", ld_resp_data, exp_ld.pop_front());
            end
            if (ld_req_ready) begin
                grants++;
                last_grant_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        c_resp_valid = 1'b0;
        u_resp_valid = 1'b0;
        if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin
                c_resp_valid = 1'b1;
                c_resp_rdata = model_rdata(c_rd_addr);
            end
        end
        if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) u_resp_valid = 1'b1;
        end
        if (last_ready && ld_pending.size() != 0) void'(ld_pending.pop_front());
        if (!rst_ && !sb_cache_busy) begin
            sb_head_en  = 1'b0;
            sb_head_unc = 1'b0;
        end
        drive_ld();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_c.size() != 0 || exp_u.size() != 0 || exp_ld.size() != 0 ||
                ld_pending.size() != 0 || c_cnt != 0 || u_cnt != 0 ||
                sb_head_en || sb_head_unc) && n < budget) begin
            tick();
            n++;
        end
        check({tag, " completed in budget"}, 32'(n < budget), 32'd1);
        repeat (2) tick();
    endtask

    task automatic wait_c_hs(input string tag, input int budget);
        int n  = 0;
        int h0 = c_hs_cnt;
        while (c_hs_cnt == h0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, " dcache accept"}, 32'(c_hs_cnt - h0), 32'd1);
    endtask

    initial begin
        int p0, g0, r0, h0, uh0;
        checks = 0; passed = 0; cyc = 0;
        c_hs_cnt = 0; u_hs_cnt = 0; pops = 0; grants = 0; resps = 0;
        c_cnt = 0; u_cnt = 0; c_lat = 1; u_lat = 5;
        last_grant_cyc = 0; last_resp_cyc = 0; last_ready = 1'b0; c_rd_addr = 32'h0;
        rst_ = 1'b1; flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = 32'h0;
        sb_head_en = 1'b0; sb_head_unc = 1'b0; sb_head_addr = 32'h0;
        sb_head_data = 32'h0; sb_head_wen = 4'h0; sb_allow_in = 1'b1;
        c_req_ready = 1'b1; c_resp_valid = 1'b0; c_resp_rdata = 32'h0;
        u_req_ready = 1'b1; u_resp_valid = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst c_req_valid", 32'(c_req_valid), 32'd0);
        check("rst u_req_valid", 32'(u_req_valid), 32'd0);
        check("rst ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        check("rst ld_resp_data", ld_resp_data, 32'd0);
        check("rst c_req_addr", c_req_addr, 32'd0);
        check("rst c_req_wdata", c_req_wdata, 32'd0);
        check("rst c_req_wen", 32'(c_req_wen), 32'd0);
        check("rst c_req_wr", 32'(c_req_wr), 32'd0);
        check("rst u_req_addr", u_req_addr, 32'd0);
        check("rst u_req_wdata", u_req_wdata, 32'd0);
        check("rst u_req_wen", 32'(u_req_wen), 32'd0);
        check("rst sb_cache_busy", 32'(sb_cache_busy), 32'd1);
        rst_ = 1'b0;
        tick();
        check("idle ld_req_ready", 32'(ld_req_ready), 32'd0);
        check("idle sb_cache_busy", 32'(sb_cache_busy), 32'd1);

        // Single load with empty head
        p0 = pops;
        ld_pending.push_back(32'h0000_1000);
        exp_load(32'h0000_1000, 1'b1);
        drive_ld();
        drain("load", 50);
        check("load latency", 32'(last_resp_cyc - last_grant_cyc), 32'd3);
        check("load no pop", 32'(pops - p0), 32'd0);

        // Cached head entry drains to dcache
        p0 = pops;
        sb_head_en = 1'b1; sb_head_addr = 32'h0000_2000;
        sb_head_data = 32'h1122_3344; sb_head_wen = 4'hF;
        exp_store(32'h0000_2000, 32'h1122_3344, 4'hF);
        drain("cached store", 50);
        check("cached store pops", 32'(pops - p0), 32'd1);

        // Uncached head entry goes to the uncached port
        p0 = pops; h0 = c_hs_cnt; uh0 = u_hs_cnt;
        sb_head_unc = 1'b1; sb_head_addr = 32'hBFD0_0000;
        sb_head_data = 32'hCAFE_F00D; sb_head_wen = 4'b0011;
        exp_u.push_back('{1'b1, 32'hBFD0_0000, 32'hCAFE_F00D, 4'b0011});
        drain("uncached store", 60);
        check("uncached pops", 32'(pops - p0), 32'd1);
        check("uncached no dcache req", 32'(c_hs_cnt - h0), 32'd0);
        check("uncached one bus req", 32'(u_hs_cnt - uh0), 32'd1);

        // Starvation limit, run twice to show the counter restarts from 0
        for (int r = 0; r < 2; r++) begin
            p0 = pops; g0 = grants;
            sb_head_en = 1'b1; sb_head_addr = 32'h0000_3000 + 32'(r * 16);
            sb_head_data = 32'hA0A0_0000 + 32'(r); sb_head_wen = 4'b1100;
            for (int i = 0; i < 6; i++) begin
                ld_pending.push_back(32'h0000_0100 + 32'(r * 64 + i * 4));
                if (i == 4) exp_store(sb_head_addr, sb_head_data, 4'b1100);
                exp_load(32'h0000_0100 + 32'(r * 64 + i * 4), 1'b1);
            end
            drive_ld();
            drain("starvation", 300);
            check("starvation grants", 32'(grants - g0), 32'd6);
            check("starvation pops", 32'(pops - p0), 32'd1);
        end

        // store_buffer full: store beats a waiting load
        sb_allow_in = 1'b0;
        sb_head_en = 1'b1; sb_head_addr = 32'h0000_4000;
        sb_head_data = 32'h0BAD_F00D; sb_head_wen = 4'b0001;
        ld_pending.push_back(32'h0000_0500);
        exp_store(32'h0000_4000, 32'h0BAD_F00D, 4'b0001);
        exp_load(32'h0000_0500, 1'b1);
        drive_ld();
        drain("full store_buffer", 80);
        sb_allow_in = 1'b1;

        // flush while in LD_WAIT: response consumed, not delivered
        c_lat = 3; r0 = resps;
        ld_pending.push_back(32'h0000_0600);
        exp_load(32'h0000_0600, 1'b0);
        drive_ld();
        wait_c_hs("flush load", 20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("flushed load", 40);
        check("flushed load no resp", 32'(resps - r0), 32'd0);

        // flush in IDLE blocks the grant; load then returns normally
        c_lat = 1; r0 = resps;
        flush = 1'b1;
        ld_pending.push_back(32'h0000_0700);
        drive_ld();
        tick();
        check("flush blocks grant", 32'(last_ready), 32'd0);
        flush = 1'b0;
        exp_load(32'h0000_0700, 1'b1);
        drain("post-flush load", 40);
        check("post-flush resp", 32'(resps - r0), 32'd1);

        // Reset while in ST_WAIT
        c_lat = 4; p0 = pops;
        sb_head_en = 1'b1; sb_head_addr = 32'h0000_9000;
        sb_head_data = 32'h5555_AAAA; sb_head_wen = 4'hF;
        exp_store(32'h0000_9000, 32'h5555_AAAA, 4'hF);
        wait_c_hs("reset store", 20);
        rst_ = 1'b1;
        tick();
        check("midrst c_req_valid", 32'(c_req_valid), 32'd0);
        check("midrst u_req_valid", 32'(u_req_valid), 32'd0);
        check("midrst sb_cache_busy", 32'(sb_cache_busy), 32'd1);
        check("midrst ld_resp_valid", 32'(ld_resp_valid), 32'd0);
        check("midrst c_req_addr", c_req_addr, 32'd0);
        check("midrst c_req_wdata", c_req_wdata, 32'd0);
        check("midrst c_req_wr", 32'(c_req_wr), 32'd0);
        rst_ = 1'b0;
        drain("after reset", 40);
        check("reset no extra pop", 32'(pops - p0), 32'd1);
        c_lat = 1; r0 = resps;
        ld_pending.push_back(32'h0000_0A00);
        exp_load(32'h0000_0A00, 1'b1);
        drive_ld();
        drain("load after reset", 40);
        check("load after reset resp", 32'(resps - r0), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
